// File: rtl/alu_operand_loader_if.sv
// Board-side bundle of the operand loader: switch/button inputs and the ALU-facing outputs.
// The loader uses the slave modport; the board/testbench side uses master.
interface alu_operand_loader_if;
    logic [7:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic       operands_valid;
    logic [3:0] state_led;
    logic       err;

    modport master (
        output sw, btn_enter, btn_clear,
        input  A, B, ALU_Sel, operands_valid, state_led, err
    );

    modport slave (
        input  sw, btn_enter, btn_clear,
        output A, B, ALU_Sel, operands_valid, state_led, err
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Operand loader for the 8-bit ALU: debounced enter/clear buttons step A -> B -> SEL -> RUN.
// Optional macro ALU_DIVZERO_GUARD_EN rejects a divide select while B is zero and raises err.
module alu_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input logic                clk,
    input logic                rst,
    alu_operand_loader_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_A, S_B, S_SEL, S_RUN} state_t;

    // Index 0 = enter, index 1 = clear
    logic [1:0]            sync1, sync2, db, db_q, press;
    logic [1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            press <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {bus.btn_clear, bus.btn_enter};
            sync2 <= sync1;
            db_q  <= db;
            for (int unsigned i = 0; i < 2; i++) begin
                // Counter only runs while a level change is pending; any reversion restarts it.
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                    db[i]  <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
                press[i] <= db[i] & ~db_q[i];
            end
        end
    end

    logic enter, clear;
    assign enter = press[0];
    assign clear = press[1];

    logic       reject;
    state_t     state, state_n;
    logic [7:0] a_q, b_q;
    logic [3:0] sel_q;
    logic       valid_q, valid_n;
    logic [3:0] led_q, led_n;

`ifdef ALU_DIVZERO_GUARD_EN
    logic err_q;
    assign reject = enter && (state == S_SEL) && (bus.sw[3:0] == 4'b0011) && (b_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        err_q <= 1'b0;
        else if (clear) err_q <= 1'b0;
        else if (enter) err_q <= reject;
    end
    assign bus.err = err_q;
`else
    assign reject  = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_A;
            valid_q <= 1'b0;
            led_q   <= 4'b0001;
        end else begin
            state   <= state_n;
            valid_q <= valid_n;
            led_q   <= led_n;
        end
    end

    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = S_A;
        end else if (enter) begin
            case (state)
                S_A:     state_n = S_B;
                S_B:     state_n = S_SEL;
                S_SEL:   state_n = reject ? S_SEL : S_RUN;
                S_RUN:   state_n = S_A;
                default: state_n = S_A;
            endcase
        end
    end

    // Decoded from next state so the registered LEDs/valid track state without lag.
    always_comb begin
        valid_n = (state_n == S_RUN);
        led_n   = 4'b0001;
        case (state_n)
            S_A:     led_n = 4'b0001;
            S_B:     led_n = 4'b0010;
            S_SEL:   led_n = 4'b0100;
            S_RUN:   led_n = 4'b1000;
            default: led_n = 4'b0001;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= '0;
        end else if (clear) begin
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= '0;
        end else if (enter) begin
            case (state)
                S_A:     a_q <= bus.sw;
                S_B:     b_q <= bus.sw;
                S_SEL:   if (!reject) sel_q <= bus.sw[3:0];
                default: ;
            endcase
        end
    end

    assign bus.A              = a_q;
    assign bus.B              = b_q;
    assign bus.ALU_Sel        = sel_q;
    assign bus.operands_valid = valid_q;
    assign bus.state_led      = led_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed scoreboard bench for alu_operand_loader with a short debounce window.
module tb_alu_operand_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alu_operand_loader_if bus();

    alu_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic       valid;
        logic [3:0] led;
        logic       err;
    } exp_t;

    exp_t        sb[$];
    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    task automatic expect_out(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                              input logic valid, input logic [3:0] led, input logic err);
        exp_t e;
        e.a = a; e.b = b; e.sel = sel; e.valid = valid; e.led = led; e.err = err;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            failed++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        cmp({tag, ".A"},     bus.A,                          e.a);
        cmp({tag, ".B"},     bus.B,                          e.b);
        cmp({tag, ".sel"},   {4'b0000, bus.ALU_Sel},         {4'b0000, e.sel});
        cmp({tag, ".valid"}, {7'b0000000, bus.operands_valid}, {7'b0000000, e.valid});
        cmp({tag, ".led"},   {4'b0000, bus.state_led},       {4'b0000, e.led});
        cmp({tag, ".err"},   {7'b0000000, bus.err},          {7'b0000000, e.err});
    endtask

    task automatic press(input logic en, input logic cl, input int unsigned len);
        @(negedge clk);
        bus.btn_enter = en;
        bus.btn_clear = cl;
        repeat (len) @(negedge clk);
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sw        = 8'h00;
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        expect_out(8'h00, 8'h00, 4'h0, 1'b0, 4'b0001, 1'b0);
        check("reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full entry
        bus.sw = 8'h2A;
        press(1'b1, 1'b0, 20);
        expect_out(8'h2A, 8'h00, 4'h0, 1'b0, 4'b0010, 1'b0);
        check("load_A");
        bus.sw = 8'h11;
        press(1'b1, 1'b0, 20);
        expect_out(8'h2A, 8'h11, 4'h0, 1'b0, 4'b0100, 1'b0);
        check("load_B");
        bus.sw = 8'h00;
        press(1'b1, 1'b0, 20);
        expect_out(8'h2A, 8'h11, 4'h0, 1'b1, 4'b1000, 1'b0);
        check("load_sel");
        bus.sw = 8'hFF;
        repeat (10) @(negedge clk);
        expect_out(8'h2A, 8'h11, 4'h0, 1'b1, 4'b1000, 1'b0);
        check("run_frozen");

        // Clear beats a simultaneous enter
        press(1'b1, 1'b1, 20);
        expect_out(8'h00, 8'h00, 4'h0, 1'b0, 4'b0001, 1'b0);
        check("clear_priority");

        // Bouncing enter must not advance
        bus.sw = 8'h55;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            bus.btn_enter = ~bus.btn_enter;
            repeat (2) @(negedge clk);
        end
        bus.btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        expect_out(8'h00, 8'h00, 4'h0, 1'b0, 4'b0001, 1'b0);
        check("glitch_reject");

        // Held enter: one advance only; a second pulse would capture B=0x44
        bus.sw = 8'h33;
        @(negedge clk);
        bus.btn_enter = 1'b1;
        repeat (20) @(negedge clk);
        bus.sw = 8'h44;
        repeat (180) @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        expect_out(8'h33, 8'h00, 4'h0, 1'b0, 4'b0010, 1'b0);
        check("held_single");

        press(1'b0, 1'b1, 20);
        expect_out(8'h00, 8'h00, 4'h0, 1'b0, 4'b0001, 1'b0);
        check("clear_only");

        // Divide select with B == 0
        bus.sw = 8'h10;
        press(1'b1, 1'b0, 20);
        bus.sw = 8'h00;
        press(1'b1, 1'b0, 20);
        bus.sw = 8'h03;
        press(1'b1, 1'b0, 20);
`ifdef ALU_DIVZERO_GUARD_EN
        expect_out(8'h10, 8'h00, 4'h0, 1'b0, 4'b0100, 1'b1);
        check("div_rejected");
        bus.sw = 8'h02;
        press(1'b1, 1'b0, 20);
        expect_out(8'h10, 8'h00, 4'h2, 1'b1, 4'b1000, 1'b0);
        check("div_retry");
`else
        expect_out(8'h10, 8'h00, 4'h3, 1'b1, 4'b1000, 1'b0);
        check("div_accepted");
`endif

        // Reset in S_SEL with enter debounce counter at 2
        press(1'b0, 1'b1, 20);
        bus.sw = 8'h21;
        press(1'b1, 1'b0, 20);
        bus.sw = 8'h22;
        press(1'b1, 1'b0, 20);
        expect_out(8'h21, 8'h22, 4'h0, 1'b0, 4'b0100, 1'b0);
        check("pre_reset_sel");
        @(negedge clk);
        bus.btn_enter = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        expect_out(8'h00, 8'h00, 4'h0, 1'b0, 4'b0001, 1'b0);
        check("reset_mid_op");
        @(negedge clk);
        rst = 1'b0;
        bus.sw = 8'h77;
        repeat (5) @(posedge clk);
        #1;
        expect_out(8'h00, 8'h00, 4'h0, 1'b0, 4'b0001, 1'b0);
        check("no_early_press");
        repeat (4) @(posedge clk);
        #1;
        expect_out(8'h77, 8'h00, 4'h0, 1'b0, 4'b0010, 1'b0);
        check("press_after_reset");
        @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        expect_out(8'h77, 8'h00, 4'h0, 1'b0, 4'b0010, 1'b0);
        check("no_release_pulse");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
